// File: rtl/noc_pkg.sv
// Shared header layout helpers and FSM state type for the NoC packetizer.
package noc_pkg;

   typedef enum logic [1:0] {
      StFill,
      StHeader,
      StPayload
   } noc_state_e;

   // Header fields, LSB first: dest_x, dest_y, src_x, src_y, len-1.
   localparam int unsigned HDR_DX_LSB = 0;

   function automatic int unsigned hdr_dy_lsb(input int unsigned xw);
      return xw;
   endfunction

   function automatic int unsigned hdr_sx_lsb(input int unsigned xw, input int unsigned yw);
      return xw + yw;
   endfunction

   function automatic int unsigned hdr_sy_lsb(input int unsigned xw, input int unsigned yw);
      return 2 * xw + yw;
   endfunction

   function automatic int unsigned hdr_len_lsb(input int unsigned xw, input int unsigned yw);
      return 2 * xw + 2 * yw;
   endfunction

   function automatic int unsigned hdr_total_w(input int unsigned xw, input int unsigned yw,
                                               input int unsigned lw);
      return 2 * xw + 2 * yw + lw;
   endfunction

   function automatic logic [63:0] place_field(input logic [31:0] v, input int unsigned w,
                                               input int unsigned lsb);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return (64'(v) & mask) << lsb;
   endfunction

   function automatic logic [63:0] pack_header(input logic [31:0] dx, input logic [31:0] dy,
                                               input logic [31:0] sx, input logic [31:0] sy,
                                               input logic [31:0] len_m1,
                                               input int unsigned xw, input int unsigned yw,
                                               input int unsigned lw);
      return place_field(dx, xw, HDR_DX_LSB)
           | place_field(dy, yw, hdr_dy_lsb(xw))
           | place_field(sx, xw, hdr_sx_lsb(xw, yw))
           | place_field(sy, yw, hdr_sy_lsb(xw, yw))
           | place_field(len_m1, lw, hdr_len_lsb(xw, yw));
   endfunction

   // Extract one field from a packed header.
   function automatic logic [31:0] unpack_field(input logic [63:0] hdr, input int unsigned lsb,
                                                input int unsigned w);
      logic [63:0] mask;
      mask = (64'd1 << w) - 64'd1;
      return 32'((hdr >> lsb) & mask);
   endfunction

endpackage

// File: rtl/noc_payload_buf.sv
// Payload store: one write port, asynchronous read. Contents are not reset.
module noc_payload_buf #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32,
   parameter int unsigned IdxW  = 2
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IdxW-1:0]  waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [IdxW-1:0]  raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem_q [Depth];

   // Data array write, no reset needed since entries are always written before read.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/noc_packetizer.sv
// Store-and-forward packetizer: buffers a stream chunk, then emits header + payload flits.
module noc_packetizer
   import noc_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MAX_ROUTERS_X = 4,
   parameter int unsigned MAX_ROUTERS_Y = 4,
   parameter int unsigned ROUTER_X      = 0,
   parameter int unsigned ROUTER_Y      = 0,
   parameter int unsigned MAX_PAYLOAD   = 4,
   localparam int unsigned X_W   = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
   localparam int unsigned Y_W   = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1,
   localparam int unsigned LEN_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   input  logic [X_W-1:0]        s_dest_x,
   input  logic [Y_W-1:0]        s_dest_y,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_header,
   output logic                  m_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [15:0]           pkt_count
);

   if (hdr_total_w(X_W, Y_W, LEN_W) > DATA_WIDTH) begin : g_hdr_too_wide
      $error("noc_packetizer: header fields do not fit in DATA_WIDTH");
   end

   noc_state_e       state_q, state_d;
   logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [LEN_W-1:0] drain_cnt_q, drain_cnt_d;
   logic [LEN_W-1:0] len_m1_q, len_m1_d;
   logic [X_W-1:0]   dest_x_q, dest_x_d;
   logic [Y_W-1:0]   dest_y_q, dest_y_d;
   logic             first_beat_q, first_beat_d;
   logic [15:0]      pkt_count_q, pkt_count_d;

   logic                  s_accept;
   logic                  m_accept;
   logic                  buf_we;
   logic [DATA_WIDTH-1:0] buf_rdata;

   noc_payload_buf #(
      .Depth (MAX_PAYLOAD),
      .Width (DATA_WIDTH),
      .IdxW  (LEN_W)
   ) u_buf (
      .clk_i   (clk),
      .we_i    (buf_we),
      .waddr_i (fill_cnt_q),
      .wdata_i (s_data),
      .raddr_i (drain_cnt_q),
      .rdata_o (buf_rdata)
   );

   assign s_ready  = (state_q == StFill) && !rst;
   assign s_accept = s_valid && s_ready;
   assign m_accept = m_valid && m_ready;

   // Next-state: fill the buffer, then hand out header and payload one flit per handshake.
   always_comb begin
      state_d      = state_q;
      fill_cnt_d   = fill_cnt_q;
      drain_cnt_d  = drain_cnt_q;
      len_m1_d     = len_m1_q;
      dest_x_d     = dest_x_q;
      dest_y_d     = dest_y_q;
      first_beat_d = first_beat_q;
      pkt_count_d  = pkt_count_q;
      buf_we       = 1'b0;
      unique case (state_q)
         StFill: begin
            if (s_accept) begin
               buf_we     = 1'b1;
               fill_cnt_d = fill_cnt_q + 1'b1;
               if (first_beat_q) begin
                  dest_x_d     = s_dest_x;
                  dest_y_d     = s_dest_y;
                  first_beat_d = 1'b0;
               end
               if (s_last || (fill_cnt_q == LEN_W'(MAX_PAYLOAD - 1))) begin
                  state_d    = StHeader;
                  len_m1_d   = fill_cnt_q;
                  fill_cnt_d = '0;
                  // A split without s_last keeps the latched dest for the next chunk.
                  if (s_last) begin
                     first_beat_d = 1'b1;
                  end
               end
            end
         end
         StHeader: begin
            if (m_ready) begin
               state_d     = StPayload;
               drain_cnt_d = '0;
            end
         end
         StPayload: begin
            if (m_ready) begin
               if (drain_cnt_q == len_m1_q) begin
                  state_d     = StFill;
                  fill_cnt_d  = '0;
                  pkt_count_d = pkt_count_q + 16'd1;
               end else begin
                  drain_cnt_d = drain_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   // Output flit, driven only from registered state so it is stable while stalled.
   always_comb begin
      m_valid  = 1'b0;
      m_header = 1'b0;
      m_last   = 1'b0;
      m_data   = '0;
      unique case (state_q)
         StHeader: begin
            m_valid  = 1'b1;
            m_header = 1'b1;
            m_data   = DATA_WIDTH'(pack_header(32'(dest_x_q), 32'(dest_y_q), 32'(ROUTER_X),
                                               32'(ROUTER_Y), 32'(len_m1_q), X_W, Y_W, LEN_W));
         end
         StPayload: begin
            m_valid = 1'b1;
            m_last  = (drain_cnt_q == len_m1_q);
            m_data  = buf_rdata;
         end
         default: ;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StFill;
         fill_cnt_q   <= '0;
         drain_cnt_q  <= '0;
         len_m1_q     <= '0;
         dest_x_q     <= '0;
         dest_y_q     <= '0;
         first_beat_q <= 1'b1;
         pkt_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         fill_cnt_q   <= fill_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         len_m1_q     <= len_m1_d;
         dest_x_q     <= dest_x_d;
         dest_y_q     <= dest_y_d;
         first_beat_q <= first_beat_d;
         pkt_count_q  <= pkt_count_d;
      end
   end

   assign pkt_count = pkt_count_q;

endmodule
